// File: rtl/dcache_controller_if.sv
// Bundle of CPU, data-cache SRAM and main-memory signals around the dcache controller.
// Signal names carry the controller's point of view (_i into it, _o out of it).
interface dcache_controller_if #(
  parameter int LINE_BITS  = 256,
  parameter int TAG_BITS   = 23,
  parameter int INDEX_BITS = 4
);
  logic                  cpu_req_i;
  logic                  cpu_wr_i;
  logic [31:0]           cpu_addr_i;
  logic [31:0]           cpu_data_i;
  logic [31:0]           cpu_data_o;
  logic                  cpu_stall_o;

  logic [INDEX_BITS-1:0] sram_addr_o;
  logic [TAG_BITS+1:0]   sram_tag_o;
  logic [LINE_BITS-1:0]  sram_data_o;
  logic                  sram_enable_o;
  logic                  sram_write_o;
  logic [TAG_BITS+1:0]   sram_tag_i;
  logic [LINE_BITS-1:0]  sram_data_i;
  logic                  sram_hit_i;

  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [31:0]           mem_addr_o;
  logic [LINE_BITS-1:0]  mem_data_o;
  logic [LINE_BITS-1:0]  mem_data_i;
  logic                  mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_data_i,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o,
    output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport slave (
    output cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_data_i,
    output sram_tag_i, sram_data_i, sram_hit_i,
    output mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Control stage for a 2-way write-back data cache: hit/miss decision, dirty-victim
// writeback, line refill from memory and pipeline stall generation.
module dcache_controller #(
  parameter int LINE_BITS = 256,
  parameter int NUM_SETS  = 16,
  parameter int TAG_BITS  = 23
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.master bus
);

  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int WORDS       = LINE_BITS / 32;
  localparam int WORD_BITS   = $clog2(WORDS);
  localparam int OFFSET_BITS = WORD_BITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    REFILL
  } state_e;

  state_e                state_q, state_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]  mem_data_q, mem_data_d;
  logic [LINE_BITS-1:0]  refill_q, refill_d;

  logic [TAG_BITS-1:0]   cpu_tag;
  logic [INDEX_BITS-1:0] cpu_index;
  logic [WORD_BITS-1:0]  cpu_word;
  logic [31:0]           cpu_line_addr;
  logic [31:0]           victim_line_addr;
  logic                  victim_dirty;
  logic [LINE_BITS-1:0]  merged_line;
  logic                  sram_write;
  logic [TAG_BITS+1:0]   sram_tag;
  logic [LINE_BITS-1:0]  sram_data;
  logic                  unused_addr_bits;

  assign cpu_tag          = bus.cpu_addr_i[31 -: TAG_BITS];
  assign cpu_index        = bus.cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign cpu_word         = bus.cpu_addr_i[2 +: WORD_BITS];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  assign cpu_line_addr    = {cpu_tag, cpu_index, {OFFSET_BITS{1'b0}}};
  assign victim_line_addr = {bus.sram_tag_i[TAG_BITS-1:0], cpu_index, {OFFSET_BITS{1'b0}}};
  assign victim_dirty     = bus.sram_tag_i[TAG_BITS+1] & bus.sram_tag_i[TAG_BITS];

  assign bus.sram_addr_o   = cpu_index;
  assign bus.sram_enable_o = bus.cpu_req_i;
  assign bus.cpu_data_o    = bus.sram_data_i[cpu_word*32 +: 32];
  assign bus.cpu_stall_o   = bus.cpu_req_i & ~((state_q == IDLE) & bus.sram_hit_i);

  assign bus.sram_write_o  = sram_write;
  assign bus.sram_tag_o    = sram_tag;
  assign bus.sram_data_o   = sram_data;

  assign bus.mem_enable_o  = mem_enable_q;
  assign bus.mem_write_o   = mem_write_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_data_o    = mem_data_q;

  // Store hits rewrite the whole line, so splice the CPU word into the looked-up line.
  always_comb begin
    merged_line = bus.sram_data_i;
    merged_line[cpu_word*32 +: 32] = bus.cpu_data_i;
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    refill_d     = refill_q;
    sram_write   = 1'b0;
    sram_tag     = '0;
    sram_data    = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (bus.sram_hit_i) begin
            if (bus.cpu_wr_i) begin
              sram_write = 1'b1;
              sram_tag   = {1'b1, 1'b1, cpu_tag};
              sram_data  = merged_line;
            end
          end else begin
            state_d = MISS;
          end
        end
      end

      // The SRAM presents the LRU victim here because the lookup missed.
      MISS: begin
        mem_enable_d = 1'b1;
        if (victim_dirty) begin
          mem_write_d = 1'b1;
          mem_addr_d  = victim_line_addr;
          mem_data_d  = bus.sram_data_i;
          state_d     = WRITEBACK;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = cpu_line_addr;
          state_d     = READMISS;
        end
      end

      // mem_enable stays high so the refill read follows the writeback back-to-back.
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = cpu_line_addr;
          state_d     = READMISS;
        end
      end

      READMISS: begin
        if (bus.mem_ack_i) begin
          refill_d     = bus.mem_data_i;
          mem_enable_d = 1'b0;
          state_d      = REFILL;
        end
      end

      REFILL: begin
        sram_write = 1'b1;
        sram_tag   = {1'b1, 1'b0, cpu_tag};
        sram_data  = refill_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      refill_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      refill_q     <= refill_d;
    end
  end

endmodule
